// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences multi-cycle multiply/divide runs and Hi/Lo writeback.
// Optional feature macro: MULDIV_ABORT_EN adds the abort_i port, which cancels a running operation.
// All outputs are flops loaded from the decode of the next state, so the request inputs have no combinational path to any output.
module muldiv_sequencer #(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mult_req_i,
    input  logic        div_req_i,
    input  logic [31:0] divisor_i,
`ifdef MULDIV_ABORT_EN
    input  logic        abort_i,
`endif
    output logic        mult_on_o,
    output logic        div_on_o,
    output logic        hi_src_o,
    output logic        lo_src_o,
    output logic        hi_write_o,
    output logic        lo_write_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        div_zero_o
);

    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT_RUN = 3'd1,
        DIV_RUN  = 3'd2,
        WB       = 3'd3,
        DZ       = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               src_q, src_d;       // 1 = last op was a mult
    logic               mult_on_d, div_on_d, write_d, busy_d, done_d, div_zero_d;

    // Next-state, counter, operation-type and output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        mult_on_d  = 1'b0;
        div_on_d   = 1'b0;
        write_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Mult wins a simultaneous request; the div request is dropped.
                if (mult_req_i) begin
                    state_d = MULT_RUN;
                    cnt_d   = CNT_W'(MULT_CYCLES - 1);
                    src_d   = 1'b1;
                end else if (div_req_i) begin
                    src_d = 1'b0;
                    if (divisor_i == 32'd0) begin
                        state_d = DZ;
                    end else begin
                        state_d = DIV_RUN;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    end
                end
            end
            MULT_RUN, DIV_RUN: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`ifdef MULDIV_ABORT_EN
                if (abort_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
`endif
            end
            WB: begin
                state_d = IDLE;
            end
            DZ: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        mult_on_d  = (state_d == MULT_RUN);
        div_on_d   = (state_d == DIV_RUN);
        write_d    = (state_d == WB);
        done_d     = (state_d == WB);
        div_zero_d = (state_d == DZ);
        busy_d     = (state_d != IDLE);
    end

    // State, counter and registered outputs; synchronous reset wins over everything
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            src_q      <= 1'b0;
            mult_on_o  <= 1'b0;
            div_on_o   <= 1'b0;
            hi_write_o <= 1'b0;
            lo_write_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            mult_on_o  <= mult_on_d;
            div_on_o   <= div_on_d;
            hi_write_o <= write_d;
            lo_write_o <= write_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            div_zero_o <= div_zero_d;
        end
    end

    // Hi/Lo mux selects follow the last accepted operation type
    assign hi_src_o = src_q;
    assign lo_src_o = src_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an operation-timeline model.
module tb_muldiv_sequencer;

    localparam int MC = 32;
    localparam int DC = 32;
`ifdef MULDIV_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    localparam int K_NONE = 0;
    localparam int K_MULT = 1;
    localparam int K_DIV  = 2;
    localparam int K_DZ   = 3;

    logic        clk = 1'b0;
    logic        reset, mult_req, div_req, abort;
    logic [31:0] divisor;
    logic        mult_on, div_on, hi_src, lo_src, hi_write, lo_write, busy, done, div_zero;

    int n_vec = 0;
    int n_err = 0;

    // Model: kind of operation in flight and cycles elapsed since its acceptance edge
    int m_kind = K_NONE;
    int m_age  = 0;
    bit m_src  = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .mult_req_i (mult_req),
        .div_req_i  (div_req),
        .divisor_i  (divisor),
`ifdef MULDIV_ABORT_EN
        .abort_i    (abort),
`endif
        .mult_on_o  (mult_on),
        .div_on_o   (div_on),
        .hi_src_o   (hi_src),
        .lo_src_o   (lo_src),
        .hi_write_o (hi_write),
        .lo_write_o (lo_write),
        .busy_o     (busy),
        .done_o     (done),
        .div_zero_o (div_zero)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int run_len(input int kind);
        return (kind == K_MULT) ? MC : DC;
    endfunction

    // Advance the model across one rising edge with the inputs presented at that edge
    task automatic model_step(input bit r, input bit m, input bit d, input logic [31:0] dv, input bit ab);
        int len;
        if (r) begin
            m_kind = K_NONE;
            m_age  = 0;
            m_src  = 1'b0;
        end else if (m_kind == K_NONE) begin
            if (m) begin
                m_kind = K_MULT; m_age = 1; m_src = 1'b1;
            end else if (d) begin
                m_kind = (dv == 32'd0) ? K_DZ : K_DIV; m_age = 1; m_src = 1'b0;
            end
        end else begin
            len = run_len(m_kind);
            if (ABORT_EN && ab && m_kind != K_DZ && m_age <= len) begin
                m_kind = K_NONE;
            end else begin
                m_age++;
                if (m_kind == K_DZ) m_kind = K_NONE;
                else if (m_age > len + 1) m_kind = K_NONE;
            end
        end
    endtask

    task automatic check_all();
        bit running, wb;
        running = (m_kind == K_MULT || m_kind == K_DIV) && m_age <= run_len(m_kind);
        wb      = (m_kind == K_MULT || m_kind == K_DIV) && m_age == run_len(m_kind) + 1;
        check_val("mult_on",  32'(mult_on),  32'(running && m_kind == K_MULT));
        check_val("div_on",   32'(div_on),   32'(running && m_kind == K_DIV));
        check_val("hi_write", 32'(hi_write), 32'(wb));
        check_val("lo_write", 32'(lo_write), 32'(wb));
        check_val("done",     32'(done),     32'(wb));
        check_val("div_zero", 32'(div_zero), 32'(m_kind == K_DZ));
        check_val("busy",     32'(busy),     32'(m_kind != K_NONE));
        check_val("hi_src",   32'(hi_src),   32'(m_src));
        check_val("lo_src",   32'(lo_src),   32'(m_src));
    endtask

    // Present inputs for one edge, step the model, then sample on the falling edge
    task automatic apply(input bit r, input bit m, input bit d, input logic [31:0] dv, input bit ab);
        reset = r; mult_req = m; div_req = d; divisor = dv; abort = ab;
        @(posedge clk);
        model_step(r, m, d, dv, ab);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; mult_req = 1'b0; div_req = 1'b0; divisor = 32'd0; abort = 1'b0;
        apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 32'd5, 1'b1);
        idle(2);

        // Single mult, then div by nonzero, then div by zero
        apply(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        idle(MC + 3);
        apply(1'b0, 1'b0, 1'b1, 32'd7, 1'b0);
        idle(DC + 3);
        apply(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        idle(3);

        // Simultaneous requests with a zero divisor: mult wins
        apply(1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
        idle(MC + 3);

        // Back-to-back: request in the WB cycle is lost
        apply(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        idle(MC - 1);
        apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 32'd3, 1'b0);
        idle(3);

        // Reset at run cycle 10 of a mult, then a fresh div completes
        apply(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        idle(9);
        apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(2);
        apply(1'b0, 1'b0, 1'b1, 32'd9, 1'b0);
        idle(DC + 3);

        // Abort at div run cycle 5; mult_req during a run is ignored
        apply(1'b0, 1'b0, 1'b1, 32'd11, 1'b0);
        idle(4);
        apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        idle(3);
        apply(1'b0, 1'b0, 1'b1, 32'd13, 1'b0);
        idle(19);
        apply(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        idle(DC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter MULT_CYCLES, default 32: number of run cycles the multiplier needs, legal range 1..63.
REQ-002 Parameter DIV_CYCLES, default 32: number of run cycles the divider needs, legal range 1..63.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port mult_req, input, 1: control unit requests a mult (A*B).
REQ-006 Port div_req, input, 1: control unit requests a div (A/B).
REQ-007 Port divisor, input, 32: B operand, checked for zero on div acceptance.
REQ-008 Port abort, input, 1: cancel the running operation; present only when MULDIV_ABORT_EN is defined.
REQ-009 Port mult_on, output, 1: multiplier enable.
REQ-010 Port div_on, output, 1: divider enable.
REQ-011 Port hi_src and lo_src, output, 1 each: Hi/Lo input mux select; 1 = multiplier, 0 = divider.
REQ-012 Port hi_write and lo_write, output, 1 each: Hi/Lo register write enables.
REQ-013 Port busy, output, 1: an operation is in progress.
REQ-014 Port done, output, 1: one-cycle pulse marking result writeback.
REQ-015 Port div_zero, output, 1: one-cycle divide-by-zero exception pulse to the control unit.

Function
REQ-016 The FSM SHALL have states IDLE, MULT_RUN, DIV_RUN, WB and DZ.
REQ-017 In IDLE with mult_req=1, the next state SHALL be MULT_RUN and the 6-bit counter SHALL load MULT_CYCLES-1.
REQ-018 In IDLE with div_req=1, mult_req=0 and divisor!=0, the next state SHALL be DIV_RUN and the counter SHALL load DIV_CYCLES-1.
REQ-019 In IDLE with div_req=1, mult_req=0 and divisor==0, the next state SHALL be DZ; no run and no Hi/Lo write occur.
REQ-020 When mult_req and div_req are both 1 in IDLE, mult SHALL win and div_req SHALL be dropped, not queued.
REQ-021 In MULT_RUN, mult_on=1 and busy=1; in DIV_RUN, div_on=1 and busy=1; the counter SHALL decrement every cycle.
REQ-022 A RUN state at counter==0 SHALL go to WB on the next edge.
REQ-023 Run length SHALL be exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-024 WB SHALL last one cycle, with:
- hi_write=lo_write=1, done=1, busy=1;
- hi_src=lo_src=1 if the operation was a mult, 0 if a div;
- next state IDLE.
REQ-025 Latency: for a request accepted at edge 0, the WB cycle SHALL follow edge N, where N is the run cycle count.
REQ-026 DZ SHALL last one cycle with div_zero=1, busy=1, done=0 and all write enables 0; next state IDLE.
REQ-027 mult_req and div_req SHALL be ignored outside IDLE.
REQ-028 A request asserted in the WB or DZ cycle SHALL be lost; it is accepted only from IDLE.
REQ-029 hi_src and lo_src SHALL hold the last operation type outside WB; they change only on acceptance.
REQ-030 All outputs SHALL be registered-state decodes, free of combinational paths from the request inputs.

Reset
REQ-031 reset=1 at a rising edge SHALL force IDLE, counter=0, hi_src=lo_src=0, and deassert all other outputs.
REQ-032 reset SHALL take priority over every request and over abort.
REQ-033 Reset during a RUN state SHALL discard the operation with no Hi/Lo write.

Configuration
REQ-034 With macro MULDIV_ABORT_EN defined:
- abort=1 in a RUN state SHALL force IDLE on the next edge, with no WB, done=0 and no write;
- abort SHALL be ignored in IDLE, WB and DZ.
REQ-035 Without MULDIV_ABORT_EN, the abort port and its logic SHALL be absent, and a RUN state always completes.

Verification
REQ-036 Mult with default parameters: mult_req=1 for one cycle in IDLE -> mult_on high 32 cycles; then one WB cycle with hi_write=lo_write=done=1 and hi_src=lo_src=1; busy low after.
REQ-037 Div by nonzero with DIV_CYCLES=32: div_req=1 with divisor=7 -> div_on high 32 cycles; then WB with hi_src=lo_src=0 and done=1.
REQ-038 Div by zero: div_req=1 with divisor=0 -> next cycle div_zero=1 and done=0, with div_on, hi_write and lo_write never asserted; IDLE the following cycle.
REQ-039 Simultaneous requests: mult_req=div_req=1 with divisor=0 -> MULT_RUN entered, div_zero never asserted.
REQ-040 Reset mid-op: reset=1 at run cycle 10 of a mult -> all outputs 0 next cycle, no WB pulse; a fresh div_req then completes normally.
REQ-041 With MULDIV_ABORT_EN: abort=1 at div run cycle 5 -> IDLE next cycle, no done or write pulse; a mult_req at run cycle 20 is also ignored.
